// File: rtl/crc_stream_engine.sv
// Multi-channel streaming CRC engine: input FIFO, byte-per-cycle CRC update,
// per-channel contexts (init/poly/ctrl/running CRC) and a valid/ready result port.
module crc_stream_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NUM_CH     = 2,
    localparam int unsigned NB = DATA_WIDTH / 8,
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [CW-1:0]         cfg_ch,
    input  logic [1:0]            cfg_addr,
    input  logic [31:0]           cfg_wdata,
    output logic                  cfg_err,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [CW-1:0]         s_ch,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [BW-1:0]         s_bytes,
    input  logic                  s_first,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CW-1:0]         m_ch,
    output logic [31:0]           m_crc,
    input  logic [CW-1:0]         rd_ch,
    output logic [31:0]           rd_crc,
    output logic                  busy
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [CW-1:0]         ch;
        logic [DATA_WIDTH-1:0] data;
        logic [BW-1:0]         bytes;
        logic                  first;
        logic                  last;
    } word_t;

    typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

    // Active-width mask selected by CTRL[1:0]
    function automatic logic [31:0] size_mask(input logic [1:0] sz);
        logic [31:0] m;
        case (sz)
            2'b00:   m = 32'hFFFF_FFFF;
            2'b01:   m = 32'h0000_FFFF;
            2'b10:   m = 32'h0000_00FF;
            default: m = 32'h0000_007F;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] din,
                                             input logic [31:0] poly, input logic [3:0] ctrl);
        logic [31:0] mask;
        logic [31:0] top;
        logic [31:0] c;
        logic [7:0]  d;
        logic        fb;
        mask = size_mask(ctrl[1:0]);
        top  = mask ^ (mask >> 1);
        for (int i = 0; i < 8; i++) d[i] = ctrl[2] ? din[7-i] : din[i];
        c = crc & mask;
        for (int i = 7; i >= 0; i--) begin
            fb = ((c & top) != 32'd0) ^ d[i];
            c  = (c << 1) & mask;
            if (fb) c = c ^ (poly & mask);
        end
        return c;
    endfunction

    // Optional reflection of the low W bits of the result
    function automatic logic [31:0] out_xform(input logic [31:0] c, input logic [3:0] ctrl);
        logic [31:0] r;
        logic [31:0] res;
        for (int i = 0; i < 32; i++) r[i] = c[31-i];
        case (ctrl[1:0])
            2'b00:   res = r;
            2'b01:   res = r >> 16;
            2'b10:   res = r >> 24;
            default: res = r >> 25;
        endcase
        return ctrl[3] ? res : c;
    endfunction

    state_t        state, state_d;
    word_t         mem [FIFO_DEPTH];
    word_t         in_word;
    word_t         w;
    logic [BW-1:0] w_idx;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, empty, push, pop, last_byte;
    logic          crc_step, cfg_block, cfg_ok;
    logic [31:0]   seed, crc_nxt, ctx_init, ctx_crc, ctx_poly;
    logic [3:0]    ctx_ctrl;
    logic [7:0]    cur_byte;

    logic [31:0] init_q [NUM_CH];
    logic [31:0] poly_q [NUM_CH];
    logic [3:0]  ctrl_q [NUM_CH];
    logic [31:0] crc_q  [NUM_CH];

    assign full      = (count == (PW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign push      = s_valid && !full;
    assign s_ready   = !full;
    assign busy      = (state != IDLE) || !empty;
    assign last_byte = (w_idx == w.bytes);
    assign cfg_block = (state != IDLE) && (cfg_ch == w.ch);
    assign cfg_ok    = cfg_we && !cfg_block && (32'(cfg_ch) < NUM_CH);

    always_comb begin
        in_word       = '0;
        in_word.ch    = s_ch;
        in_word.data  = s_data;
        in_word.bytes = (NB == 1) ? '0 : s_bytes;
        in_word.first = s_first;
        in_word.last  = s_last;
    end

    // Input FIFO; a full FIFO refuses pushes even when popping the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = PROC;
                end
            end
            PROC: begin
                if (last_byte) begin
                    if (w.last)      state_d = DONE;
                    else if (!empty) pop     = 1'b1;
                    else             state_d = IDLE;
                end
            end
            DONE: begin
                if (m_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = PROC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath for the byte currently in the working register
    always_comb begin
        ctx_init = '0;
        ctx_crc  = '0;
        ctx_poly = '0;
        ctx_ctrl = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w.ch == CW'(c)) begin
                ctx_init = init_q[c];
                ctx_crc  = crc_q[c];
                ctx_poly = poly_q[c];
                ctx_ctrl = ctrl_q[c];
            end
        end
        crc_step = (state == PROC);
        cur_byte = w.data[{w_idx, 3'b000} +: 8];
        seed     = (w.first && (w_idx == '0)) ? ctx_init : ctx_crc;
        crc_nxt  = crc_byte(seed, cur_byte, ctx_poly, ctx_ctrl);
    end

    always_comb begin
        rd_crc = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch == CW'(c)) rd_crc = crc_q[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w     <= '0;
            w_idx <= '0;
        end else if (pop) begin
            w     <= mem[rd_ptr];
            w_idx <= '0;
        end else if (crc_step && !last_byte) begin
            w_idx <= w_idx + 1'b1;
        end
    end

    // Channel contexts; the working channel is never a config target while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                init_q[c] <= 32'hFFFF_FFFF;
                poly_q[c] <= 32'h04C1_1DB7;
                ctrl_q[c] <= 4'h0;
                crc_q[c]  <= 32'hFFFF_FFFF;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (crc_step && (w.ch == CW'(c))) crc_q[c] <= crc_nxt;
                if (cfg_ok && (cfg_ch == CW'(c))) begin
                    case (cfg_addr)
                        2'd0: init_q[c] <= cfg_wdata & size_mask(ctrl_q[c][1:0]);
                        2'd1: poly_q[c] <= cfg_wdata & size_mask(ctrl_q[c][1:0]);
                        2'd2: begin
                            ctrl_q[c] <= cfg_wdata[3:0];
                            if (cfg_wdata[4]) crc_q[c] <= init_q[c];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_ch    <= '0;
            m_crc   <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && cfg_block;
            m_valid <= (state_d == DONE);
            if (crc_step && last_byte && w.last) begin
                m_ch  <= w.ch;
                m_crc <= out_xform(crc_nxt, ctx_ctrl);
            end
        end
    end

endmodule
